// File: rtl/rsa_pkg.sv
// Shared types for the systolic-array feeder: adder-mode codes and FSM states.
package rsa_pkg;

    typedef logic [1:0] add_mode_t;

    localparam add_mode_t ADD_NONE = 2'b00;
    localparam add_mode_t ADD_M    = 2'b01;
    localparam add_mode_t SUB_M    = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_e;

endpackage

// File: rtl/rsa_feeder_skew_line.sv
// DEPTH-stage delay line with synchronous clear; DEPTH=0 degenerates to a wire.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         sys_rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = ^{clk, sys_rst};
            assign dout = din;
        end else begin : g_regs
            logic [W-1:0] stage_q [DEPTH];
            logic [W-1:0] stage_d [DEPTH];

            always_comb begin
                stage_d[0] = din;
                for (int s = 1; s < DEPTH; s++) begin
                    stage_d[s] = stage_q[s-1];
                end
            end

            always_ff @(posedge clk) begin
                for (int s = 0; s < DEPTH; s++) begin
                    if (sys_rst) begin
                        stage_q[s] <= '0;
                    end else begin
                        stage_q[s] <= stage_d[s];
                    end
                end
            end

            assign dout = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/rsa_feeder.sv
// Drive-side sequencer for the X-by-Y PE array: skews operands onto the array
// edges, waits for the pipeline to drain, then strobes the per-row M merge.
module rsa_feeder
    import rsa_pkg::*;
#(
    parameter int X      = 4,
    parameter int Y      = 4,
    parameter int RSA_DW = 32,
    parameter int CNT_W  = 8,
    parameter int PE_LAT = 2
) (
    input  logic                clk,
    input  logic                sys_rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    len,
    input  logic [1:0]          mode,
    input  logic [X*RSA_DW-1:0] a_vec,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [Y*RSA_DW-1:0] b_vec,
    input  logic                b_valid,
    output logic                b_ready,
    output logic [X*RSA_DW-1:0] A_data,
    output logic [Y*RSA_DW-1:0] B_data,
    output logic [Y-1:0]        new_cal_en,
    output logic [Y-1:0]        new_cal_done,
    output logic [2*X-1:0]      M_adder_mode,
    output logic                busy,
    output logic                done
);

    localparam int DRAIN_CYC = X + Y + PE_LAT;
    localparam int PH_MAX    = (DRAIN_CYC > X) ? DRAIN_CYC : X;
    localparam int PH_W      = $clog2(PH_MAX);
    localparam int BW        = RSA_DW + 2;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [PH_W-1:0]  phase_q, phase_d;
    add_mode_t        mode_q, mode_d;
    logic             done_q, done_d;

    logic fire;
    logic last_beat;

    assign a_ready   = (state_q == FEED) && (remaining_q != '0);
    assign b_ready   = a_ready;
    assign fire      = a_ready && a_valid && b_valid;
    assign last_beat = fire && (remaining_q == CNT_W'(1));

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            phase_q     <= '0;
            mode_q      <= ADD_NONE;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            phase_q     <= phase_d;
            mode_q      <= mode_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        phase_d     = phase_q;
        mode_d      = mode_q;
        done_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        state_d     = FEED;
                        remaining_d = len;
                        mode_d      = mode;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FEED: begin
                if (fire) begin
                    remaining_d = remaining_q - CNT_W'(1);
                    if (last_beat) begin
                        state_d = DRAIN;
                        phase_d = '0;
                    end
                end
            end
            DRAIN: begin
                if (phase_q == PH_W'(DRAIN_CYC - 1)) begin
                    state_d = OUT;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            OUT: begin
                if (phase_q == PH_W'(X - 1)) begin
                    state_d = IDLE;
                    phase_d = '0;
                    done_d  = 1'b1;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // One row at a time receives the latched mode while in OUT.
    always_comb begin
        M_adder_mode = '0;
        for (int r = 0; r < X; r++) begin
            if ((state_q == OUT) && (phase_q == PH_W'(r))) begin
                M_adder_mode[2*r +: 2] = mode_q;
            end
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;

    // Non-firing cycles inject zeros so bubbles travel down the same skew.
    logic [X*RSA_DW-1:0] a_data_d, a_data_q;
    logic [Y*RSA_DW-1:0] b_data_d, b_data_q;
    logic [Y-1:0]        cal_en_d, cal_en_q;
    logic [Y-1:0]        cal_done_d, cal_done_q;

    genvar gi;
    generate
        for (gi = 0; gi < X; gi++) begin : g_a_lane
            logic [RSA_DW-1:0] a_in;
            logic [RSA_DW-1:0] a_skew;
            assign a_in = fire ? a_vec[gi*RSA_DW +: RSA_DW] : '0;
            skew_line #(.DEPTH(gi), .W(RSA_DW)) u_skew (
                .clk     (clk),
                .sys_rst (sys_rst),
                .din     (a_in),
                .dout    (a_skew)
            );
            assign a_data_d[gi*RSA_DW +: RSA_DW] = a_skew;
        end

        for (gi = 0; gi < Y; gi++) begin : g_b_lane
            logic [BW-1:0] b_in;
            logic [BW-1:0] b_skew;
            assign b_in = {fire, last_beat, fire ? b_vec[gi*RSA_DW +: RSA_DW] : {RSA_DW{1'b0}}};
            skew_line #(.DEPTH(gi), .W(BW)) u_skew (
                .clk     (clk),
                .sys_rst (sys_rst),
                .din     (b_in),
                .dout    (b_skew)
            );
            assign b_data_d[gi*RSA_DW +: RSA_DW] = b_skew[RSA_DW-1:0];
            assign cal_done_d[gi]                = b_skew[RSA_DW];
            assign cal_en_d[gi]                  = b_skew[RSA_DW+1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            a_data_q   <= '0;
            b_data_q   <= '0;
            cal_en_q   <= '0;
            cal_done_q <= '0;
        end else begin
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            cal_en_q   <= cal_en_d;
            cal_done_q <= cal_done_d;
        end
    end

    assign A_data       = a_data_q;
    assign B_data       = b_data_q;
    assign new_cal_en   = cal_en_q;
    assign new_cal_done = cal_done_q;

endmodule

// File: tb/tb_rsa_feeder.sv
// Directed bench for rsa_feeder: reset, skew timing, bubbles, drain/out sequencing,
// zero-length ops and mid-op reset.
module tb_rsa_feeder;
    import rsa_pkg::*;

    localparam int X      = 4;
    localparam int Y      = 4;
    localparam int RSA_DW = 32;
    localparam int CNT_W  = 8;
    localparam int PE_LAT = 2;
    localparam int DRAIN_CYC = X + Y + PE_LAT;

    logic                clk;
    logic                sys_rst;
    logic                start;
    logic [CNT_W-1:0]    len;
    logic [1:0]          mode;
    logic [X*RSA_DW-1:0] a_vec;
    logic                a_valid;
    logic                a_ready;
    logic [Y*RSA_DW-1:0] b_vec;
    logic                b_valid;
    logic                b_ready;
    logic [X*RSA_DW-1:0] A_data;
    logic [Y*RSA_DW-1:0] B_data;
    logic [Y-1:0]        new_cal_en;
    logic [Y-1:0]        new_cal_done;
    logic [2*X-1:0]      M_adder_mode;
    logic                busy;
    logic                done;

    int checks   = 0;
    int failures = 0;

    rsa_feeder #(
        .X(X), .Y(Y), .RSA_DW(RSA_DW), .CNT_W(CNT_W), .PE_LAT(PE_LAT)
    ) dut (
        .clk          (clk),
        .sys_rst      (sys_rst),
        .start        (start),
        .len          (len),
        .mode         (mode),
        .a_vec        (a_vec),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .b_vec        (b_vec),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .A_data       (A_data),
        .B_data       (B_data),
        .new_cal_en   (new_cal_en),
        .new_cal_done (new_cal_done),
        .M_adder_mode (M_adder_mode),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Lane index sits in the upper byte so lane swaps are visible.
    function automatic logic [31:0] lane_val(input int base, input int lane);
        return 32'((lane << 8) | base);
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_A"},    A_data, '0);
        check_eq({tag, "_B"},    B_data, '0);
        check_eq({tag, "_en"},   new_cal_en, '0);
        check_eq({tag, "_dn"},   new_cal_done, '0);
        check_eq({tag, "_M"},    M_adder_mode, '0);
        check_eq({tag, "_busy"}, busy, 1'b0);
        check_eq({tag, "_done"}, done, 1'b0);
        check_eq({tag, "_rdy"},  a_ready, 1'b0);
    endtask

    // Runs one op of n beats; beat k>0 is delayed by gap stall cycles in which
    // only a_valid is high. A second start is held during FEED and must be ignored.
    task automatic run_feed(input int n, input int gap, input logic [1:0] md);
        int boff[4];
        int last;
        int kk;
        int o;
        logic [X*RSA_DW-1:0] exp_a;
        logic [Y*RSA_DW-1:0] exp_b;
        logic [Y-1:0]        exp_en;
        logic [Y-1:0]        exp_dn;
        logic [7:0]          exp_m;
        logic [7:0]          md_w;

        start = 1'b1;
        len   = CNT_W'(n);
        mode  = md;
        step();
        start = 1'b0;
        check_eq("start_busy", busy, 1'b1);
        check_eq("start_rdy", a_ready, 1'b1);

        for (int k = 0; k < 4; k++) boff[k] = k + ((k > 0) ? gap : 0);
        last = boff[n-1];
        md_w = {6'b0, md};

        for (int s = 0; s <= last + 15; s++) begin
            kk = -1;
            for (int k = 0; k < n; k++) if (boff[k] == s) kk = k;
            if (kk >= 0) begin
                a_valid = 1'b1;
                b_valid = 1'b1;
                for (int i = 0; i < X; i++) a_vec[i*RSA_DW +: RSA_DW] = lane_val(8'h10 + kk, i);
                for (int j = 0; j < Y; j++) b_vec[j*RSA_DW +: RSA_DW] = lane_val(8'h20 + kk, j);
            end else if (s < last) begin
                a_valid = 1'b1;
                b_valid = 1'b0;
                a_vec   = {X{32'hDEADBEEF}};
                b_vec   = {Y{32'hCAFEF00D}};
            end else begin
                a_valid = 1'b0;
                b_valid = 1'b0;
                a_vec   = '0;
                b_vec   = '0;
            end
            if (s < last) begin
                start = 1'b1;
                len   = CNT_W'(7);
            end else begin
                start = 1'b0;
            end

            step();
            o = s + 1;

            exp_a  = '0;
            exp_b  = '0;
            exp_en = '0;
            exp_dn = '0;
            for (int k = 0; k < n; k++) begin
                for (int i = 0; i < X; i++)
                    if (o == boff[k] + i + 1) exp_a[i*RSA_DW +: RSA_DW] = lane_val(8'h10 + k, i);
                for (int j = 0; j < Y; j++)
                    if (o == boff[k] + j + 1) begin
                        exp_b[j*RSA_DW +: RSA_DW] = lane_val(8'h20 + k, j);
                        exp_en[j] = 1'b1;
                        exp_dn[j] = (k == n - 1);
                    end
            end
            exp_m = '0;
            if (o >= last + DRAIN_CYC + 1 && o <= last + DRAIN_CYC + X)
                exp_m = md_w << (2 * (o - last - DRAIN_CYC - 1));

            check_eq("A_data", A_data, exp_a);
            check_eq("B_data", B_data, exp_b);
            check_eq("cal_en", new_cal_en, exp_en);
            check_eq("cal_done", new_cal_done, exp_dn);
            check_eq("M_mode", M_adder_mode, exp_m);
            check_eq("done", done, (o == last + DRAIN_CYC + X + 1));
            check_eq("busy", busy, (o <= last + DRAIN_CYC + X));
            check_eq("a_ready", a_ready, (o <= last));
            check_eq("b_ready", b_ready, (o <= last));
        end
        $display("op len=%0d gap=%0d mode=%0d finished", n, gap, md);
    endtask

    initial begin
        sys_rst = 1'b1;
        start   = 1'b1;
        len     = CNT_W'(3);
        mode    = ADD_M;
        a_vec   = '0;
        b_vec   = '0;
        a_valid = 1'b1;
        b_valid = 1'b1;

        // Reset held with start asserted: nothing may leak out.
        for (int c = 0; c < 3; c++) begin
            step();
            check_all_zero("rst");
        end
        sys_rst = 1'b0;
        start   = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        step();
        check_all_zero("post_rst");
        $display("reset sequence done");

        // Back-to-back beats, ADD_M merge.
        run_feed(3, 0, ADD_M);

        // One b_valid stall between two beats, SUB_M merge.
        run_feed(2, 1, SUB_M);

        // Zero-length op: done pulse only.
        start = 1'b1;
        len   = '0;
        mode  = ADD_M;
        step();
        start = 1'b0;
        check_eq("len0_done", done, 1'b1);
        check_eq("len0_busy", busy, 1'b0);
        check_eq("len0_en", new_cal_en, '0);
        check_eq("len0_rdy", a_ready, 1'b0);
        step();
        check_eq("len0_done_clr", done, 1'b0);
        check_eq("len0_en2", new_cal_en, '0);
        $display("op len=0 finished");

        // Reset after the first of four beats.
        start = 1'b1;
        len   = CNT_W'(4);
        mode  = ADD_M;
        step();
        start   = 1'b0;
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < X; i++) a_vec[i*RSA_DW +: RSA_DW] = lane_val(8'h10, i);
        for (int j = 0; j < Y; j++) b_vec[j*RSA_DW +: RSA_DW] = lane_val(8'h20, j);
        step();
        check_eq("mid_A0", A_data[31:0], lane_val(8'h10, 0));
        check_eq("mid_en", new_cal_en, 4'b0001);
        sys_rst = 1'b1;
        step();
        check_all_zero("mid_rst");
        sys_rst = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_vec   = '0;
        b_vec   = '0;
        for (int c = 0; c < 4; c++) begin
            step();
            check_all_zero("after_rst");
        end
        $display("mid-op reset finished");

        run_feed(1, 0, ADD_M);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rsa_feeder.md
Name: rsa_feeder

Overview:
- Drive-side sequencer for the X-by-Y systolic PE array.
- Accepts one k-step of A (X lanes) and B (Y lanes) per handshake beat.
- Emits diagonally skewed A_data/B_data with per-column new_cal_en/new_cal_done, waits for the array to drain, then sequences the per-row M_adder_mode strobes that merge M into C.
- Sits between the operand buffers and the PE array; one matrix-multiply op per start.

Parameters:
- X, 4, PE rows (A lanes, adder rows)
- Y, 4, PE columns (B lanes, cal_en/cal_done columns)
- RSA_DW, 32, data lane width
- CNT_W, 8, width of the k-length counter
- PE_LAT, 2, extra pipeline cycles of a PE/adder beyond the skew

Ports:
- clk  in  1  clock
- sys_rst  in  1  synchronous active-high reset
- start  in  1  op request, sampled only in IDLE
- len  in  CNT_W  k-steps for the op, latched at start
- mode  in  2  adder mode for the op, latched at start
- a_vec  in  X*RSA_DW  A column for one k-step, lane i at [i*RSA_DW +: RSA_DW]
- a_valid  in  1  a_vec valid
- a_ready  out  1  a_vec accepted when a_valid & a_ready & b_valid
- b_vec  in  Y*RSA_DW  B row for one k-step
- b_valid  in  1  b_vec valid
- b_ready  out  1  equals a_ready
- A_data  out  X*RSA_DW  skewed west-edge data
- B_data  out  Y*RSA_DW  skewed north-edge data
- new_cal_en  out  Y  per-column calc enable
- new_cal_done  out  Y  per-column last-step strobe
- M_adder_mode  out  2*X  per-row adder mode, row i at [2*i +: 2]
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at op completion

Behaviour:
- Reset: state IDLE; all skew registers cleared; A_data, B_data, new_cal_en, new_cal_done, M_adder_mode, busy, done, a_ready all 0. Reset mid-op aborts immediately; no further strobes.
- Handshake:
  - a_ready = b_ready = (state==FEED) and remaining>0.
  - Beat fires only when a_valid & b_valid & a_ready. A single valid does not fire and nothing is consumed.
- Skew:
  - Lane i of A reaches A_data i+1 cycles after the beat.
  - Lane j of B and bits new_cal_en[j] / new_cal_done[j] reach the outputs j+1 cycles after the beat.
  - A non-firing cycle in FEED/DRAIN inserts a bubble: data 0, cal_en 0, cal_done 0, shifted through the same skew.
  - new_cal_done accompanies the beat carrying remaining==1 and is 1 on exactly one cycle per column.
- FSM:
  - IDLE: start & len!=0 -> latch len/mode, FEED. start & len==0 -> done pulse next cycle, stay IDLE. start while not IDLE is ignored.
  - FEED: remaining decrements per fired beat. The last beat moves to DRAIN on the next cycle.
  - DRAIN: counter runs X+Y+PE_LAT cycles while the skew flushes with bubbles; then OUT.
  - OUT: X cycles. In OUT cycle r, M_adder_mode row r = latched mode; all other rows 00. After the cycle with r=X-1, the next cycle is IDLE with done=1.
- Widths: remaining is CNT_W bits with no wrap. len = 2^CNT_W - 1 is legal. Data passes unmodified; no arithmetic on data.
- busy is registered: it rises the cycle after start is accepted and falls with done.

Decomposition:
- Package rsa_pkg:
  - Adder mode constants ADD_NONE=2'b00, ADD_M=2'b01, SUB_M=2'b10.
  - FSM state encoding IDLE/FEED/DRAIN/OUT.
- Sub-module skew_line (params DEPTH, W): DEPTH-stage register chain with synchronous reset, DEPTH=0 is a wire.
  - Instantiate per A lane with DEPTH=i.
  - Instantiate per B lane with DEPTH=j, using W=RSA_DW+2 to carry cal_en/cal_done.
  - Output register is in the top module.

Test Plan:
All scenarios use X=Y=4, RSA_DW=32, PE_LAT=2.
1. Reset/idle: hold sys_rst 3 cycles with start=1 -> every output 0, busy 0, no done.
2. len=3, a/b valid every cycle, a_vec lanes = 0x10+k, b_vec lanes = 0x20+k:
   - A_data lane 2 shows 0x10,0x11,0x12 starting beat0+3 cycles.
   - new_cal_en[3] high cycles beat0+4..+6; new_cal_done[3] high only at +6.
3. len=2, b_valid dropped one cycle between beats:
   - One bubble, seen on every column with cal_en=0 and data 0.
   - Exactly 2 beats consumed; a_ready stays high during the stall.
4. Drain/out sequencing, mode=ADD_M:
   - After the last beat: DRAIN 10 cycles.
   - M_adder_mode rows 0..3 each 2'b01 for one cycle, in successive cycles.
   - done pulses the following cycle; busy falls with done.
5. start with len=0 -> done pulses next cycle, no cal_en. A second start during FEED is ignored.
6. sys_rst asserted mid-FEED after 1 of 4 beats -> next cycle all outputs 0, IDLE. A fresh start with len=1 completes normally.
